// File: rtl/l2_resp_pkg.sv
// Shared types and constants for the L2 TCDM responder: response tag layout,
// port identifiers and the default out-of-range read pattern.
package l2_resp_pkg;

  localparam logic PORT_RO = 1'b0;
  localparam logic PORT_WO = 1'b1;

  localparam logic [31:0] DEFAULT_OOR_RDATA = 32'hBADA_CCE5;

  typedef struct packed {
    logic valid;
    logic port_id;
    logic is_read;
    logic oor;
  } resp_tag_t;

endpackage

// File: rtl/l2_rr_arbiter_2.sv
// Two-way round-robin arbiter with combinational one-hot grant.
// Bit 0 is the ro port, bit 1 the wo port.
module l2_rr_arbiter_2
  import l2_resp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic rr_ptr;

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (rr_ptr == PORT_WO) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Only a contested grant moves the pointer, and it moves onto the loser.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= PORT_RO;
    end else if (req == 2'b11) begin
      rr_ptr <= ~rr_ptr;
    end
  end

endmodule

// File: rtl/l2_tcdm_responder.sv
// L2 memory-side responder: arbitrates the uDMA ro/wo TCDM ports onto one
// single-port SRAM and returns one rvalid per grant after MEM_LATENCY cycles.
module l2_tcdm_responder
  import l2_resp_pkg::*;
#(
  parameter int                         L2_DATA_WIDTH  = 32,
  parameter int                         MEM_ADDR_WIDTH = 15,
  parameter logic [31:0]                BASE_ADDR      = 32'h1C00_0000,
  parameter int                         MEM_LATENCY    = 1,
  parameter logic [L2_DATA_WIDTH-1:0]   OOR_RDATA      = L2_DATA_WIDTH'(DEFAULT_OOR_RDATA)
) (
  input  logic                         sys_clk_i,
  input  logic                         sys_rst_i,

  input  logic                         L2_ro_req_i,
  input  logic                         L2_ro_wen_i,
  output logic                         L2_ro_gnt_o,
  input  logic [31:0]                  L2_ro_addr_i,
  input  logic [L2_DATA_WIDTH/8-1:0]   L2_ro_be_i,
  input  logic [L2_DATA_WIDTH-1:0]     L2_ro_wdata_i,
  output logic                         L2_ro_rvalid_o,
  output logic [L2_DATA_WIDTH-1:0]     L2_ro_rdata_o,

  input  logic                         L2_wo_req_i,
  input  logic                         L2_wo_wen_i,
  output logic                         L2_wo_gnt_o,
  input  logic [31:0]                  L2_wo_addr_i,
  input  logic [L2_DATA_WIDTH/8-1:0]   L2_wo_be_i,
  input  logic [L2_DATA_WIDTH-1:0]     L2_wo_wdata_i,
  output logic                         L2_wo_rvalid_o,
  output logic [L2_DATA_WIDTH-1:0]     L2_wo_rdata_o,

  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0]    mem_addr_o,
  output logic [L2_DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [L2_DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic [L2_DATA_WIDTH-1:0]     mem_rdata_i
);

  logic [1:0]               gnt;
  logic                     any_gnt;
  logic                     sel_wo;
  logic                     wen;
  logic [31:0]              addr;
  logic [31:0]              offset;
  logic                     in_range;
  resp_tag_t                tag_in;
  resp_tag_t                tag_p [MEM_LATENCY];
  resp_tag_t                tail;
  logic                     resp_vld;
  logic [L2_DATA_WIDTH-1:0] resp_data;

  l2_rr_arbiter_2 u_arb (
    .clk (sys_clk_i),
    .rst (sys_rst_i),
    .req ({L2_wo_req_i, L2_ro_req_i}),
    .gnt (gnt)
  );

  assign L2_ro_gnt_o = gnt[0];
  assign L2_wo_gnt_o = gnt[1];
  assign any_gnt     = |gnt;
  assign sel_wo      = gnt[1];

  assign wen  = sel_wo ? L2_wo_wen_i  : L2_ro_wen_i;
  assign addr = sel_wo ? L2_wo_addr_i : L2_ro_addr_i;

  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  assign offset   = addr - BASE_ADDR;
  assign in_range = (offset >> (MEM_ADDR_WIDTH + 2)) == 32'd0;

  assign mem_req_o   = any_gnt & in_range;
  assign mem_we_o    = ~wen;
  assign mem_addr_o  = offset[MEM_ADDR_WIDTH+1:2];
  assign mem_be_o    = sel_wo ? L2_wo_be_i    : L2_ro_be_i;
  assign mem_wdata_o = sel_wo ? L2_wo_wdata_i : L2_ro_wdata_i;

  assign tag_in = '{valid: any_gnt, port_id: sel_wo, is_read: wen, oor: ~in_range};

  // Stage boundary: response tags, one slot per SRAM latency cycle
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      for (int i = 0; i < MEM_LATENCY; i++) tag_p[i] <= '0;
    end else begin
      tag_p[0] <= tag_in;
      for (int i = 1; i < MEM_LATENCY; i++) tag_p[i] <= tag_p[i-1];
    end
  end

  assign tail     = tag_p[MEM_LATENCY-1];
  assign resp_vld = tail.valid & ~sys_rst_i;

  always_comb begin
    resp_data = '0;
    if (tail.is_read) resp_data = tail.oor ? OOR_RDATA : mem_rdata_i;
  end

  assign L2_ro_rvalid_o = resp_vld & (tail.port_id == PORT_RO);
  assign L2_wo_rvalid_o = resp_vld & (tail.port_id == PORT_WO);
  assign L2_ro_rdata_o  = L2_ro_rvalid_o ? resp_data : '0;
  assign L2_wo_rdata_o  = L2_wo_rvalid_o ? resp_data : '0;

endmodule

// File: tb/tb_l2_tcdm_responder.sv
// Randomized bench for l2_tcdm_responder: two instances (latency 1 and 3)
// share stimulus; a transaction-level reference model predicts every output.
module tb_l2_tcdm_responder;

  localparam logic [31:0] BASE   = 32'h1C00_0000;
  localparam logic [31:0] OOR    = 32'hBADA_CCE5;
  localparam logic [31:0] SPAN   = 32'h0002_0000;
  localparam int          NWORDS = 32768;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    bit          port;
    logic [31:0] rdata;
  } resp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ro_req, ro_wen, wo_req, wo_wen;
  logic [31:0] ro_addr, wo_addr, ro_wdata, wo_wdata;
  logic [3:0]  ro_be, wo_be;

  logic        ro_gnt_a, wo_gnt_a, ro_rv_a, wo_rv_a, m_req_a, m_we_a;
  logic [31:0] ro_rd_a, wo_rd_a, m_wdata_a, m_rdata_a;
  logic [14:0] m_addr_a;
  logic [3:0]  m_be_a;
  logic        ro_gnt_b, wo_gnt_b, ro_rv_b, wo_rv_b, m_req_b, m_we_b;
  logic [31:0] ro_rd_b, wo_rd_b, m_wdata_b, m_rdata_b;
  logic [14:0] m_addr_b;
  logic [3:0]  m_be_b;

  l2_tcdm_responder #(.MEM_LATENCY(1)) dut_a (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .L2_ro_req_i(ro_req), .L2_ro_wen_i(ro_wen), .L2_ro_gnt_o(ro_gnt_a),
    .L2_ro_addr_i(ro_addr), .L2_ro_be_i(ro_be), .L2_ro_wdata_i(ro_wdata),
    .L2_ro_rvalid_o(ro_rv_a), .L2_ro_rdata_o(ro_rd_a),
    .L2_wo_req_i(wo_req), .L2_wo_wen_i(wo_wen), .L2_wo_gnt_o(wo_gnt_a),
    .L2_wo_addr_i(wo_addr), .L2_wo_be_i(wo_be), .L2_wo_wdata_i(wo_wdata),
    .L2_wo_rvalid_o(wo_rv_a), .L2_wo_rdata_o(wo_rd_a),
    .mem_req_o(m_req_a), .mem_we_o(m_we_a), .mem_addr_o(m_addr_a),
    .mem_be_o(m_be_a), .mem_wdata_o(m_wdata_a), .mem_rdata_i(m_rdata_a)
  );

  l2_tcdm_responder #(.MEM_LATENCY(3)) dut_b (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .L2_ro_req_i(ro_req), .L2_ro_wen_i(ro_wen), .L2_ro_gnt_o(ro_gnt_b),
    .L2_ro_addr_i(ro_addr), .L2_ro_be_i(ro_be), .L2_ro_wdata_i(ro_wdata),
    .L2_ro_rvalid_o(ro_rv_b), .L2_ro_rdata_o(ro_rd_b),
    .L2_wo_req_i(wo_req), .L2_wo_wen_i(wo_wen), .L2_wo_gnt_o(wo_gnt_b),
    .L2_wo_addr_i(wo_addr), .L2_wo_be_i(wo_be), .L2_wo_wdata_i(wo_wdata),
    .L2_wo_rvalid_o(wo_rv_b), .L2_wo_rdata_o(wo_rd_b),
    .mem_req_o(m_req_b), .mem_we_o(m_we_b), .mem_addr_o(m_addr_b),
    .mem_be_o(m_be_b), .mem_wdata_o(m_wdata_b), .mem_rdata_i(m_rdata_b)
  );

  function automatic logic [31:0] init_word(int i);
    return (i < 8) ? (32'hCAFE_0000 + 32'(i)) : 32'h0;
  endfunction

  // SRAM models: byte-enabled writes, reads delayed by each instance's latency
  logic [31:0] mem_a [NWORDS];
  logic [31:0] mem_b [NWORDS];
  logic [31:0] rp_a;
  logic [31:0] rp_b [3];

  initial begin
    for (int i = 0; i < NWORDS; i++) begin
      mem_a[i] <= init_word(i);
      mem_b[i] <= init_word(i);
    end
  end

  always @(posedge clk) begin
    if (m_req_a && m_we_a)
      for (int k = 0; k < 4; k++) if (m_be_a[k]) mem_a[m_addr_a][k*8 +: 8] <= m_wdata_a[k*8 +: 8];
    rp_a <= (m_req_a && !m_we_a) ? mem_a[m_addr_a] : 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (m_req_b && m_we_b)
      for (int k = 0; k < 4; k++) if (m_be_b[k]) mem_b[m_addr_b][k*8 +: 8] <= m_wdata_b[k*8 +: 8];
    rp_b[0] <= (m_req_b && !m_we_b) ? mem_b[m_addr_b] : 32'hDEAD_BEEF;
    rp_b[1] <= rp_b[0];
    rp_b[2] <= rp_b[1];
  end

  assign m_rdata_a = rp_a;
  assign m_rdata_b = rp_b[2];

  // Reference model state
  logic [31:0] ref_mem [NWORDS];
  txn_t        ro_q[$];
  txn_t        wo_q[$];
  resp_t       sched_a [int];
  resp_t       sched_b [int];
  bit          rr;
  int          cyc;
  int          n_cmp;
  int          n_bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic txn_t mk(logic w, logic [31:0] a, logic [3:0] b, logic [31:0] d);
    txn_t t;
    t.wen = w; t.addr = a; t.be = b; t.wdata = d;
    return t;
  endfunction

  task automatic check_resp(input string nm, input resp_t sched[int], input logic rv_ro,
                            input logic rv_wo, input logic [31:0] rd_ro, input logic [31:0] rd_wo,
                            output bit hit);
    logic        e_ro, e_wo;
    logic [31:0] e_rd;
    e_ro = 1'b0; e_wo = 1'b0; e_rd = 32'h0; hit = 1'b0;
    if (sched.exists(cyc)) begin
      hit = 1'b1;
      e_ro = (sched[cyc].port == 1'b0);
      e_wo = (sched[cyc].port == 1'b1);
      e_rd = sched[cyc].rdata;
    end
    chk({nm, "_ro_rvalid"}, 64'(rv_ro), 64'(e_ro));
    chk({nm, "_wo_rvalid"}, 64'(rv_wo), 64'(e_wo));
    chk({nm, "_ro_rdata"}, 64'(rd_ro), 64'(e_ro ? e_rd : 32'h0));
    chk({nm, "_wo_rdata"}, 64'(rd_wo), 64'(e_wo ? e_rd : 32'h0));
  endtask

  task automatic check_cycle();
    bit          e_ro_g, e_wo_g, hit;
    txn_t        t;
    logic [31:0] off, rd;
    bit          inr;
    if (rst) begin
      rr = 1'b0;
      sched_a.delete();
      sched_b.delete();
    end
    check_resp("a", sched_a, ro_rv_a, wo_rv_a, ro_rd_a, wo_rd_a, hit);
    if (hit) sched_a.delete(cyc);
    check_resp("b", sched_b, ro_rv_b, wo_rv_b, ro_rd_b, wo_rd_b, hit);
    if (hit) sched_b.delete(cyc);

    e_ro_g = !rst && ro_q.size() > 0 && (wo_q.size() == 0 || rr == 1'b0);
    e_wo_g = !rst && wo_q.size() > 0 && !e_ro_g;
    chk("a_ro_gnt", 64'(ro_gnt_a), 64'(e_ro_g));
    chk("a_wo_gnt", 64'(wo_gnt_a), 64'(e_wo_g));
    chk("b_ro_gnt", 64'(ro_gnt_b), 64'(e_ro_g));
    chk("b_wo_gnt", 64'(wo_gnt_b), 64'(e_wo_g));

    if (!rst && ro_q.size() > 0 && wo_q.size() > 0) rr = e_ro_g ? 1'b1 : 1'b0;

    if (e_ro_g || e_wo_g) begin
      t   = e_ro_g ? ro_q.pop_front() : wo_q.pop_front();
      off = t.addr - BASE;
      inr = off < SPAN;
      chk("a_mem_req", 64'(m_req_a), 64'(inr));
      chk("b_mem_req", 64'(m_req_b), 64'(inr));
      if (inr) begin
        chk("a_mem_addr", 64'(m_addr_a), 64'(off / 4));
        chk("b_mem_addr", 64'(m_addr_b), 64'(off / 4));
        chk("a_mem_we", 64'(m_we_a), 64'(!t.wen));
        chk("a_mem_be", 64'(m_be_a), 64'(t.be));
        chk("a_mem_wdata", 64'(m_wdata_a), 64'(t.wdata));
      end
      if (!t.wen) rd = 32'h0;
      else if (inr) rd = ref_mem[off / 4];
      else rd = OOR;
      if (inr && !t.wen)
        for (int k = 0; k < 4; k++) if (t.be[k]) ref_mem[off / 4][k*8 +: 8] = t.wdata[k*8 +: 8];
      sched_a[cyc + 1] = '{port: e_wo_g, rdata: rd};
      sched_b[cyc + 3] = '{port: e_wo_g, rdata: rd};
    end else begin
      chk("a_mem_req_idle", 64'(m_req_a), 64'(0));
      chk("b_mem_req_idle", 64'(m_req_b), 64'(0));
    end
  endtask

  task automatic cycle_step(input bit r);
    @(posedge clk);
    #1;
    rst    = r;
    ro_req = ro_q.size() > 0;
    wo_req = wo_q.size() > 0;
    if (ro_req) begin
      ro_wen = ro_q[0].wen; ro_addr = ro_q[0].addr; ro_be = ro_q[0].be; ro_wdata = ro_q[0].wdata;
    end
    if (wo_req) begin
      wo_wen = wo_q[0].wen; wo_addr = wo_q[0].addr; wo_be = wo_q[0].be; wo_wdata = wo_q[0].wdata;
    end
    @(negedge clk);
    check_cycle();
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while ((ro_q.size() > 0 || wo_q.size() > 0) && n < 200) begin
      cycle_step(1'b0);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 64'(1), 64'(0));
    repeat (4) cycle_step(1'b0);
  endtask

  function automatic logic [31:0] rand_addr();
    int s = $urandom_range(0, 9);
    if (s == 0) return BASE - 32'd4;
    if (s == 1) return BASE + SPAN + 32'($urandom_range(0, 15));
    if (s == 2) return 32'h0000_1000;
    return BASE + 32'($urandom_range(0, 63));
  endfunction

  function automatic txn_t rand_txn();
    return mk(1'($urandom_range(0, 1)), rand_addr(), 4'($urandom), $urandom);
  endfunction

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; rr = 1'b0;
    rst = 1'b1;
    ro_req = 1'b0; ro_wen = 1'b1; ro_addr = '0; ro_be = '0; ro_wdata = '0;
    wo_req = 1'b0; wo_wen = 1'b1; wo_addr = '0; wo_be = '0; wo_wdata = '0;
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = init_word(i);

    repeat (2) cycle_step(1'b1);

    ro_q.push_back(mk(1'b1, BASE + 32'h10, 4'hF, 32'h0));
    drain();

    wo_q.push_back(mk(1'b0, BASE + 32'h20, 4'b0011, 32'h1234_5678));
    cycle_step(1'b0);
    ro_q.push_back(mk(1'b1, BASE + 32'h20, 4'hF, 32'h0));
    drain();

    ro_q.push_back(mk(1'b1, BASE + 32'h4, 4'hF, 32'h0));
    wo_q.push_back(mk(1'b1, BASE + 32'h8, 4'hF, 32'h0));
    repeat (2) cycle_step(1'b0);
    cycle_step(1'b1);
    repeat (4) cycle_step(1'b0);

    for (int i = 0; i < 8; i++) begin
      ro_q.push_back(mk(1'b1, BASE + 32'(4 * i), 4'hF, 32'h0));
      wo_q.push_back(mk(1'b0, BASE + 32'(4 * (i + 16)), 4'hF, $urandom));
    end
    drain();

    ro_q.push_back(mk(1'b1, 32'h1BFF_FFFC, 4'hF, 32'h0));
    wo_q.push_back(mk(1'b0, BASE + SPAN, 4'hF, 32'hFFFF_FFFF));
    drain();
    ro_q.push_back(mk(1'b1, BASE, 4'hF, 32'h0));
    drain();

    for (int i = 0; i < 16; i++) wo_q.push_back(mk(1'b0, BASE + 32'(4 * i), 4'hF, $urandom));
    drain();

    for (int i = 0; i < 400; i++) begin
      if (ro_q.size() < 3 && $urandom_range(0, 2) != 0) ro_q.push_back(rand_txn());
      if (wo_q.size() < 3 && $urandom_range(0, 2) != 0) wo_q.push_back(rand_txn());
      cycle_step($urandom_range(0, 59) == 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
